seven_segment_scanner: RTL and testbench



---
 rtl/seven_segment_scanner.sv | 125 ++++++++++++
 tb/tb_seven_segment_scanner.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/seven_segment_scanner.sv
// Four-digit multiplexed hex display driver with a debounced two-button up/down counter.
// The left button decrements the shown value, the right button increments it, and both wrap.
module seven_segment_scanner #(
  parameter int SCAN_DIV        = 50000,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        left_button,
  input  logic        right_button,
  output logic [6:0]  segment_bits,
  output logic [3:0]  grounds,
  output logic [15:0] value
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam int SC_W = $clog2(SCAN_DIV);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(SCAN_DIV - 1);

  typedef enum logic {BLANK, DRIVE} scan_state_t;

  // Bit 0 tracks the left button, bit 1 the right button.
  logic [1:0]            sync1, sync2, stable, stable_d, press;
  logic [1:0][DB_W-1:0]  db_cnt;

  scan_state_t           state;
  logic [1:0]            idx;
  logic [SC_W-1:0]       presc;
  logic [3:0]            nibble;

  function automatic logic [6:0] decode(input logic [3:0] hex);
    case (hex)
      4'h0: decode = 7'b1111110;
      4'h1: decode = 7'b0110000;
      4'h2: decode = 7'b1101101;
      4'h3: decode = 7'b1111001;
      4'h4: decode = 7'b0110011;
      4'h5: decode = 7'b1011011;
      4'h6: decode = 7'b1011111;
      4'h7: decode = 7'b1110000;
      4'h8: decode = 7'b1111111;
      4'h9: decode = 7'b1111011;
      4'hA: decode = 7'b1110111;
      4'hB: decode = 7'b0011111;
      4'hC: decode = 7'b1001110;
      4'hD: decode = 7'b0111101;
      4'hE: decode = 7'b1001111;
      4'hF: decode = 7'b1000111;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1    <= '0;
      sync2    <= '0;
      stable   <= '0;
      stable_d <= '0;
      db_cnt   <= '0;
    end else begin
      // NOTE: non-blocking keeps sync2 one full cycle behind sync1, which the synchronizer relies on.
      sync1    <= {right_button, left_button};
      sync2    <= sync1;
      stable_d <= stable;
      for (int b = 0; b < 2; b++) begin
        if (sync2[b] == stable[b]) begin
          db_cnt[b] <= '0;
        end else if (db_cnt[b] == DB_LAST) begin
          stable[b] <= sync2[b];
          db_cnt[b] <= '0;
        end else begin
          db_cnt[b] <= db_cnt[b] + 1'b1;
        end
      end
    end
  end

  // Only the accepted press edge counts; release and held levels produce nothing.
  assign press = stable & ~stable_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else begin
      case (press)
        2'b10:   value <= value + 1'b1;
        2'b01:   value <= value - 1'b1;
        default: value <= value;
      endcase
    end
  end

  assign nibble = value[{idx, 2'b00} +: 4];

  // One dark cycle between digits keeps two digits from ever being lit together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= BLANK;
      idx          <= '0;
      presc        <= '0;
      grounds      <= 4'b1111;
      segment_bits <= '0;
    end else begin
      case (state)
        BLANK: begin
          grounds      <= 4'b1111;
          segment_bits <= '0;
          state        <= DRIVE;
        end
        DRIVE: begin
          grounds      <= ~(4'b0001 << idx);
          segment_bits <= decode(nibble);
          if (presc == SC_LAST) begin
            presc <= '0;
            idx   <= idx + 1'b1;
            state <= BLANK;
          end else begin
            presc <= presc + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Directed bench for seven_segment_scanner with SCAN_DIV=4 and DEBOUNCE_CYCLES=8.
// Expected outputs are queued before each step and popped against the DUT after it.
module tb_seven_segment_scanner;

  localparam int SEL_VALUE = 0;
  localparam int SEL_GND   = 1;
  localparam int SEL_SEG   = 2;

  typedef struct {
    string       tag;
    logic [15:0] exp;
    int          sel;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        left_button;
  logic        right_button;
  logic [6:0]  segment_bits;
  logic [3:0]  grounds;
  logic [15:0] value;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t sb[$];

  logic [6:0] seg_tab [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  seven_segment_scanner #(
    .SCAN_DIV        (4),
    .DEBOUNCE_CYCLES (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .left_button  (left_button),
    .right_button (right_button),
    .segment_bits (segment_bits),
    .grounds      (grounds),
    .value        (value)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] observe(input int sel);
    case (sel)
      SEL_VALUE: return value;
      SEL_GND:   return {12'h000, grounds};
      default:   return {9'h000, segment_bits};
    endcase
  endfunction

  task automatic push(input string tag, input logic [15:0] exp, input int sel);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    e.sel = sel;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, observe(e.sel), e.exp);
    end
  endtask

  // Scan position for the c-th rising edge after reset release: 1 blank + 4 lit cycles per digit.
  task automatic push_scan(input string tag, input int c, input logic [15:0] v);
    int p, d, ph;
    logic [3:0] nib;
    p  = (c - 1) % 20;
    d  = p / 5;
    ph = p % 5;
    nib = 4'((v >> (4 * d)) & 16'h000F);
    if (ph == 0) begin
      push({tag, "_gnd"}, 16'h000F, SEL_GND);
      push({tag, "_seg"}, 16'h0000, SEL_SEG);
    end else begin
      push({tag, "_gnd"}, {12'h000, ~(4'b0001 << d)}, SEL_GND);
      push({tag, "_seg"}, {9'h000, seg_tab[nib]}, SEL_SEG);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic scan_step(input string tag, input logic [15:0] v);
    push_scan(tag, cyc + 1, v);
    tick();
    drain();
  endtask

  task automatic value_step(input string tag, input logic [15:0] v);
    push(tag, v, SEL_VALUE);
    tick();
    drain();
  endtask

  task automatic press(input logic l, input logic r);
    left_button  = l;
    right_button = r;
    repeat (12) tick();
    left_button  = 1'b0;
    right_button = 1'b0;
    repeat (12) tick();
  endtask

  task automatic push_reset_state(input string tag);
    push({tag, "_value"}, 16'h0000, SEL_VALUE);
    push({tag, "_gnd"},   16'h000F, SEL_GND);
    push({tag, "_seg"},   16'h0000, SEL_SEG);
  endtask

  initial begin
    rst_n        = 1'b0;
    left_button  = 1'b0;
    right_button = 1'b0;
    repeat (3) @(negedge clk);
    push_reset_state("reset");
    drain();

    rst_n = 1'b1;
    cyc   = 0;
    for (int i = 0; i < 40; i++) scan_step("scan_idle", 16'h0000);

    // Right input bouncing with a 3-cycle period never holds long enough to be accepted.
    for (int i = 0; i < 40; i++) begin
      right_button = ((i % 3) != 2);
      value_step("bounce", 16'h0000);
    end
    right_button = 1'b0;
    for (int i = 0; i < 20; i++) value_step("bounce_settle", 16'h0000);

    // Held press: the value moves on the 10th edge after the first sampling edge, then stays.
    right_button = 1'b1;
    for (int i = 1; i <= 30; i++) value_step("hold_latency", (i >= 11) ? 16'h0001 : 16'h0000);
    right_button = 1'b0;
    for (int i = 0; i < 20; i++) value_step("release", 16'h0001);

    press(1'b1, 1'b0);
    push("left_to_zero", 16'h0000, SEL_VALUE);
    drain();
    press(1'b1, 1'b0);
    push("left_wrap", 16'hFFFF, SEL_VALUE);
    drain();
    for (int i = 0; i < 20; i++) scan_step("scan_ffff", 16'hFFFF);

    press(1'b1, 1'b1);
    push("both_buttons", 16'hFFFF, SEL_VALUE);
    drain();
    press(1'b0, 1'b1);
    push("right_wrap", 16'h0000, SEL_VALUE);
    drain();

    repeat (18) press(1'b0, 1'b1);
    push("count_up", 16'h0012, SEL_VALUE);
    drain();
    for (int i = 0; i < 20; i++) scan_step("scan_0012", 16'h0012);

    // Move into a lit cycle, then pull reset between clock edges.
    for (int i = 0; i < 2 && ((cyc - 1) % 5) == 0; i++) tick();
    push_scan("pre_reset", cyc, 16'h0012);
    drain();
    #2 rst_n = 1'b0;
    #1 push_reset_state("async_reset");
    drain();
    @(negedge clk);
    push_reset_state("reset_held");
    drain();
    rst_n = 1'b1;
    cyc   = 0;
    for (int i = 0; i < 20; i++) scan_step("scan_after_reset", 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
